if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the pipeline controller (Ctl) and the register-file/decode datapath.
- Owns the PC and drives the instruction-memory address. Applies stall, jump and branch redirects from the controller and the ID-stage comparator.
- Holds the IF/ID pipeline register (instruction, PC+4) and keeps small fetch performance counters.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global step/run enable; 0 freezes all state in this block.
- imem_addr  out  32  byte address to instruction memory; equals pc.
- imem_data  in  32  instruction at imem_addr, combinational read. Ctl's `ins` is wired to this same net.
- f_choke  in  1  stall/squash request from Ctl.
- f_jmp  in  1  J-type jump decoded at IF by Ctl; already gated low by Ctl during choke.
- br_taken  in  1  beq in ID resolved taken (Ctl f_branch AND ID register-compare equal).
- br_target  in  32  branch target computed in ID.
- pc  out  32  current fetch PC.
- ifid_ins  out  32  IF/ID instruction register.
- ifid_pc4  out  32  IF/ID PC+4 register.
- cnt_fetch  out  CNT_W  instructions accepted into IF/ID.
- cnt_stall  out  CNT_W  cycles with f_choke=1 and br_taken=0.
- cnt_flush  out  CNT_W  taken redirects (jump or branch).

Behaviour:
- Reset (rst=0, async):
  - pc=PC_RESET; ifid_ins=0 (nop); ifid_pc4=0; all counters 0.
  - Release is synchronous to clk: the first fetch is from PC_RESET on the first edge after release.
- pc4 = pc + 32'd4, wrapping modulo 2^32.
- jmp_target = {pc4[31:28], imem_data[25:0], 2'b00}.
- Next-PC priority, evaluated each rising edge when en=1:
  1. br_taken=1: pc<=br_target; ifid_ins<=0; ifid_pc4<=0; cnt_flush++.
  2. else f_choke=1: pc holds (refetch); ifid_ins<=0; ifid_pc4<=0; cnt_stall++.
  3. else f_jmp=1: pc<=jmp_target; ifid_ins<=imem_data; ifid_pc4<=pc4; cnt_fetch++; cnt_flush++. The jump itself enters IF/ID and becomes a nop-like control bubble in Ctl; there is no delay slot.
  4. else: pc<=pc4; ifid_ins<=imem_data; ifid_pc4<=pc4; cnt_fetch++.
- br_taken overrides f_choke in every case.
  - Ctl always chokes the cycle after a beq, so a taken branch redirects on that choke cycle.
  - A not-taken branch refetches the held pc.
- br_taken and f_jmp together: the branch wins and the jump instruction is squashed.
- en=0: pc, IF/ID register and counters hold; imem_addr still equals pc. Inputs are ignored.
- Counters saturate at all-ones; they do not wrap.
- imem_addr[1:0] is always 0 for word-aligned targets. Misaligned br_target is passed through unchanged and is not checked.
- Latency: the instruction at pc appears on ifid_ins one cycle after the edge on which it was fetched.
- Reset asserted mid-operation clears everything immediately (async), with no dependence on clk or en.

Decomposition:
- Shared package `mips_pkg`:
  - opcode constants (OP_RTYPE=6'b000000, OP_J=6'b000010, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_LW=6'b100011, OP_SW=6'b101011);
  - NOP=32'h0000_0000.
- One natural sub-module: `sat_counter` (CNT_W, async active-low reset, inc input, saturating), instantiated three times.
- The next-PC mux and IF/ID register stay inline.

Test Plan:
- Reset then straight-line: rst low, then high, en=1, imem returns 32'h2008_0001 for every address -> pc steps 0,4,8,C. ifid_pc4 = 4,8,C. cnt_fetch=3 after 3 edges.
- Stall: at pc=8 assert f_choke for 2 cycles -> pc stays 8, ifid_ins=0 for both cycles, cnt_stall=2. Resumes at 8 -> C.
- Jump: pc=4, imem_data=32'h0800_0010, f_jmp=1 -> next pc=32'h40, ifid_ins=32'h0800_0010, ifid_pc4=8, cnt_flush=1.
- Branch taken during choke: f_choke=1, br_taken=1, br_target=32'h100 -> pc=32'h100, ifid_ins=0, cnt_flush++, cnt_stall unchanged.
- Branch not taken during choke: f_choke=1, br_taken=0 at pc=C -> pc stays C, next cycle fetches C.
- Async reset and freeze:
  - en=0 for 3 cycles -> no state change.
  - Drop rst between clock edges -> pc=PC_RESET and ifid_ins=0 immediately.
  - Preload a counter at 16'hFFFF and fetch -> counter stays 16'hFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode encodings and the canonical nop word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; sticks at all-ones.
module sat_counter
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, redirect mux, IF/ID register and
// fetch performance counters.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             f_choke,
    input  logic             f_jmp,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_ins,
    output logic [31:0]      ifid_pc4,
    output logic [CNT_W-1:0] cnt_fetch,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    logic [31:0] pc4;
    logic [31:0] jmp_target;
    logic        fetch_inc;
    logic        stall_inc;
    logic        flush_inc;

    always_comb begin
        pc4        = pc + 32'd4;
        jmp_target = {pc4[31:28], imem_data[25:0], 2'b00};
        // A taken branch outranks choke and jump alike.
        fetch_inc  = en & ~br_taken & ~f_choke;
        stall_inc  = en & ~br_taken & f_choke;
        flush_inc  = en & (br_taken | (~f_choke & f_jmp));
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= PC_RESET;
            ifid_ins <= NOP;
            ifid_pc4 <= '0;
        end else if (en) begin
            if (br_taken) begin
                pc       <= br_target;
                ifid_ins <= NOP;
                ifid_pc4 <= '0;
            end else if (f_choke) begin
                ifid_ins <= NOP;
                ifid_pc4 <= '0;
            end else begin
                // The jump itself enters IF/ID; there is no delay slot.
                pc       <= f_jmp ? jmp_target : pc4;
                ifid_ins <= imem_data;
                ifid_pc4 <= pc4;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_fetch (
        .clk (clk),
        .rst (rst),
        .inc (fetch_inc),
        .cnt (cnt_fetch)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (cnt_stall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (cnt_flush)
    );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural fetch model predicts the state
// after each edge; a negedge monitor compares the DUT against it.
module tb_if_stage;

    localparam int unsigned CNT_W   = 16;
    localparam logic [31:0] PC_RST  = 32'h0000_0000;
    localparam int unsigned CNT_MAX = 65535;

    logic             clk;
    logic             rst;
    logic             en;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic             f_choke;
    logic             f_jmp;
    logic             br_taken;
    logic [31:0]      br_target;
    logic [31:0]      pc;
    logic [31:0]      ifid_ins;
    logic [31:0]      ifid_pc4;
    logic [CNT_W-1:0] cnt_fetch;
    logic [CNT_W-1:0] cnt_stall;
    logic [CNT_W-1:0] cnt_flush;

    if_stage #(.PC_RESET(PC_RST), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .f_choke   (f_choke),
        .f_jmp     (f_jmp),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pc        (pc),
        .ifid_ins  (ifid_ins),
        .ifid_pc4  (ifid_pc4),
        .cnt_fetch (cnt_fetch),
        .cnt_stall (cnt_stall),
        .cnt_flush (cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
        int unsigned fetch;
        int unsigned stall;
        int unsigned flush;
    } state_t;

    state_t m;
    state_t exp_q[$];
    int     n_checks;
    int     n_fail;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic int unsigned bump(int unsigned v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m.pc = PC_RST; m.ins = 32'h0; m.pc4 = 32'h0;
        m.fetch = 0; m.stall = 0; m.flush = 0;
    endtask

    task automatic check_now(string tag, state_t e);
        chk({tag, ".pc"}, pc, e.pc);
        chk({tag, ".imem_addr"}, imem_addr, e.pc);
        chk({tag, ".ifid_ins"}, ifid_ins, e.ins);
        chk({tag, ".ifid_pc4"}, ifid_pc4, e.pc4);
        chk({tag, ".cnt_fetch"}, 32'(cnt_fetch), e.fetch);
        chk({tag, ".cnt_stall"}, 32'(cnt_stall), e.stall);
        chk({tag, ".cnt_flush"}, 32'(cnt_flush), e.flush);
    endtask

    // Drive one cycle of inputs, clock it, then predict and enqueue the result.
    task automatic step(input logic e, input logic ch, input logic j, input logic b,
                        input logic [31:0] tgt, input logic [31:0] data);
        logic [31:0] next4;
        en = e; f_choke = ch; f_jmp = j; br_taken = b; br_target = tgt; imem_data = data;
        @(posedge clk);
        #1;
        if (e) begin
            next4 = m.pc + 32'd4;
            if (b) begin
                m.pc = tgt; m.ins = 32'h0; m.pc4 = 32'h0; m.flush = bump(m.flush);
            end else if (ch) begin
                m.ins = 32'h0; m.pc4 = 32'h0; m.stall = bump(m.stall);
            end else begin
                m.ins = data; m.pc4 = next4; m.fetch = bump(m.fetch);
                if (j) begin
                    m.pc = (next4 & 32'hF000_0000) | ((data & 32'h03FF_FFFF) << 2);
                    m.flush = bump(m.flush);
                end else begin
                    m.pc = next4;
                end
            end
        end
        exp_q.push_back(m);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check_now("cyc", exp_q.pop_front());
    end

    localparam logic [31:0] ADDI = 32'h2008_0001;
    localparam logic [31:0] JINS = 32'h0800_0010;

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0; en = 1'b0; f_choke = 1'b0; f_jmp = 1'b0; br_taken = 1'b0;
        br_target = 32'h0; imem_data = 32'h0;
        model_reset();
        #2;
        check_now("reset", m);
        @(negedge clk);
        rst = 1'b1;

        // Straight-line fetch from reset.
        repeat (3) step(1, 0, 0, 0, 32'h0, ADDI);
        // Taken branch during choke to 8, then a two-cycle stall and resume.
        step(1, 1, 0, 1, 32'h8, ADDI);
        repeat (2) step(1, 1, 0, 0, 32'h0, ADDI);
        step(1, 0, 0, 0, 32'h0, ADDI);
        // Not-taken branch at C refetches C.
        step(1, 1, 0, 0, 32'h200, ADDI);
        step(1, 0, 0, 0, 32'h0, ADDI);
        // Redirect to 4, then the jump.
        step(1, 1, 0, 1, 32'h4, ADDI);
        step(1, 0, 1, 0, 32'h0, JINS);
        // Taken branch during choke to 0x100.
        step(1, 1, 0, 1, 32'h100, ADDI);
        // Branch and jump together: branch wins.
        step(1, 0, 1, 1, 32'h300, JINS);
        // Freeze: inputs ignored.
        repeat (3) step(0, $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), $urandom, $urandom);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, tgt, $urandom);
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check_now("async_rst", m);
        #1;
        rst = 1'b1;

        // Drive cnt_fetch into saturation.
        for (int i = 0; i < int'(CNT_MAX) + 5; i++) step(1, 0, 0, 0, 32'h0, ADDI);
        @(negedge clk);
        #1;
        chk("sat.cnt_fetch", 32'(cnt_fetch), 32'h0000_FFFF);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
